gs_rref_engine: RTL and testbench
=================================

# gs_rref_engine

GF(2) Gaussian-elimination engine sitting directly downstream of the error-space generation controller in the ROLLO encrypt datapath. It receives the `wr` support vectors of E, each `m` bits, as a streamed burst and reduces them in place to reduced row-echelon form. It reports whether E has full rank, then streams the reduced rows back so the controller can write them to E_rref before hashing.

## Interface
- `m`, default 101: vector width (field extension degree).
- `wr`, default 5: number of rows (dimension of E).

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle command strobe, qualified by `mode`.
- `mode`  in  1  0 = load and eliminate; 1 = read out reduced rows.
- `din`  in  m  row input during load.
- `finish`  out  1  one-cycle pulse: elimination complete (mode 0) or first readout row valid (mode 1).
- `full_rank`  out  1  1 if rank == `wr`; valid from elimination `finish` until the next mode-0 `start`.
- `dout`  out  m  row output during readout; 0 otherwise.

## Operation
- Row store: `wr` registers `row[0..wr-1]`, rank counter `rk` (width clog2(wr+1)), column counter `col`.
- States: IDLE, LOAD, ELIM, READ.
- IDLE: `start`&&!`mode` → LOAD, clear `full_rank`, `rk`=0; `start`&&`mode` → READ.
- LOAD: `din` sampled on the `start` cycle and the next `wr-1` cycles into `row[0]..row[wr-1]`; → ELIM with `col`=m-1.
- ELIM, one column per cycle: find lowest index r ≥ `rk` with `row[r][col]`=1. If found: swap `row[r]` and `row[rk]`, XOR the pivot row into every other row (all indices) with bit `col` set, `rk`++. Otherwise the rows are unchanged. `col`-- afterward.
- ELIM exits after processing column 0 (see Configuration for early exit), pulses `finish`, sets `full_rank` = (`rk`==`wr`), → IDLE.
- READ: `dout` = `row[wr-1]`, `row[wr-2]`, …, `row[0]` on consecutive cycles; `finish` pulses with the first row; → IDLE after the last row. The row store is not modified.
- Result: pivots are in descending column order. `row[0]` holds the highest pivot; zero rows sit at the highest indices.
- `start` outside IDLE is ignored.
- Mode-1 `start` with no prior elimination reads the current store (zeros after reset).
- Reset in any state: → IDLE; rows, `rk`, `col` cleared; outputs 0.

## Timing
- Reset values: `finish`=0, `full_rank`=0, `dout`=0.
- Mode-0 `start` at cycle T: rows captured at T..T+wr-1. Column m-1-j is processed at T+wr+j. `finish`=1 at the cycle after the last processed column; `full_rank` updates in the same cycle.
- Full scan: `finish` at T+wr+m.
- Mode-1 `start` at cycle R: `finish`=1 and `dout`=`row[wr-1]` at R+1. `dout`=`row[wr-1-i]` at R+1+i. `dout`=0 from R+1+wr.
- Earliest accepted next `start`: the cycle after `finish` (mode 0) or after the last row (mode 1).

## Configuration
- `GS_EARLY_EXIT_EN` defined: ELIM also terminates after the column where `rk` reaches `wr`. `finish` arrives at T+wr+j+1, where j is that column's scan index.
- Undefined: all `m` columns are always scanned. Latency is constant (T+wr+m) regardless of data, which is required for constant-time builds.

## Test plan
- Rows 1<<100, 1<<99, 1<<98, 1<<97, 1<<96 → `full_rank`=1, rows unchanged; `finish` at T+106 (T+10 with `GS_EARLY_EXIT_EN`).
- Rows A, A, B, C, 0 with A=1<<100, B=1<<50|1, C=1<<50 → `full_rank`=0, `rk`=3; `row[0]`=A, `row[1]`=1<<50, `row[2]`=1, `row[3]`=`row[4]`=0.
- All-zero rows → `full_rank`=0, `finish` at T+106 in both configurations.
- After case 1, mode-1 `start` at R → `finish` at R+1 with `dout`=1<<96; 1<<97 … 1<<100 at R+2..R+5; `dout`=0 at R+6.
- Mode-0 `start` during ELIM → ignored, result identical to the undisturbed run.
- `rst` asserted mid-ELIM → next cycle all outputs 0, state IDLE. A fresh run after reset gives correct results.

Source files
------------

// File: rtl/gs_rref_engine.sv
// GF(2) Gauss-Jordan engine: loads wr rows of m bits, reduces them to RREF one column per cycle.
// Optional GS_EARLY_EXIT_EN stops the column scan once rank reaches wr (data-dependent latency).
module gs_rref_engine #(
    parameter int m  = 101,
    parameter int wr = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [m-1:0] din,
    output logic         finish,
    output logic         full_rank,
    output logic [m-1:0] dout
);
    localparam int RKW = $clog2(wr + 1);
    localparam int CW  = (m > 1) ? $clog2(m) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, ELIM, READ} state_t;
    state_t state, state_nxt;

    logic [m-1:0]   row      [wr];
    logic [m-1:0]   row_elim [wr];
    logic [RKW-1:0] rk, rk_nxt;
    logic [CW-1:0]  col;
    logic [RKW-1:0] idx;
    logic           elim_end;

    // Pivot search, swap and XOR elimination for the current column, all in one cycle.
    always_comb begin
        logic           found;
        logic [RKW-1:0] pidx;
        logic [m-1:0]   prow;
        logic [m-1:0]   krow;
        logic [m-1:0]   src;
        found = 1'b0;
        pidx  = '0;
        prow  = '0;
        krow  = '0;
        src   = '0;
        for (int unsigned i = 0; i < wr; i++) begin
            if (RKW'(i) == rk)
                krow = row[i];
            if (!found && RKW'(i) >= rk && row[i][col]) begin
                found = 1'b1;
                pidx  = RKW'(i);
                prow  = row[i];
            end
        end
        for (int unsigned i = 0; i < wr; i++) begin
            if (!found)
                src = row[i];
            else if (RKW'(i) == rk)
                src = prow;
            else if (RKW'(i) == pidx)
                src = krow;
            else
                src = row[i];
            if (found && RKW'(i) != rk && src[col])
                src = src ^ prow;
            row_elim[i] = src;
        end
        rk_nxt = found ? rk + 1'b1 : rk;
`ifdef GS_EARLY_EXIT_EN
        elim_end = (col == '0) || (rk_nxt == RKW'(wr));
`else
        elim_end = (col == '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // The registered finish flag marks the wrap-up cycle of ELIM, so a new start is
    // only accepted the cycle after the finish pulse.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = mode ? READ : ((wr == 1) ? ELIM : LOAD);
            LOAD:    if (idx == RKW'(wr - 1)) state_nxt = ELIM;
            ELIM:    if (finish) state_nxt = IDLE;
            READ:    if (idx == RKW'(wr - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dout = '0;
        if (state == READ) begin
            for (int unsigned i = 0; i < wr; i++)
                if (idx == RKW'(wr - 1 - i))
                    dout = row[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < wr; i++)
                row[i] <= '0;
            rk        <= '0;
            col       <= '0;
            idx       <= '0;
            finish    <= 1'b0;
            full_rank <= 1'b0;
        end else begin
            finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !mode) begin
                        row[0]    <= din;
                        idx       <= RKW'(1);
                        rk        <= '0;
                        col       <= CW'(m - 1);
                        full_rank <= 1'b0;
                    end else if (start && mode) begin
                        idx    <= '0;
                        finish <= 1'b1;
                    end
                end
                LOAD: begin
                    for (int unsigned i = 0; i < wr; i++)
                        if (idx == RKW'(i))
                            row[i] <= din;
                    idx <= idx + 1'b1;
                end
                ELIM: begin
                    if (!finish) begin
                        for (int unsigned i = 0; i < wr; i++)
                            row[i] <= row_elim[i];
                        rk  <= rk_nxt;
                        col <= col - 1'b1;
                        if (elim_end) begin
                            finish    <= 1'b1;
                            full_rank <= (rk_nxt == RKW'(wr));
                        end
                    end
                end
                READ: idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gs_rref_engine.sv
// Directed bench for gs_rref_engine; reference is a leading-bit basis reduction sorted by pivot.
module tb_gs_rref_engine;
    localparam int M = 101;
    localparam int W = 5;
`ifdef GS_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [M-1:0] din = '0;
    logic         finish;
    logic         full_rank;
    logic [M-1:0] dout;

    gs_rref_engine #(.m(M), .wr(W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .din(din),
        .finish(finish), .full_rank(full_rank), .dout(dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [M-1:0] vin     [W];
    logic [M-1:0] mrow    [W];
    logic [M-1:0] rd_rows [W];
    int m_rank, m_lat;
    int run_t = -1, fin_cyc = -1, rd_r = -1;
    bit prev_fr = 1'b0, res_fr = 1'b0;
    logic [M-1:0] one = 1;
    logic [M-1:0] zero = '0;

    task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent rows become unique basis vectors keyed by leading bit; reducing them
    // ascending and listing by descending pivot yields the unique RREF.
    task automatic model_compute();
        logic [M-1:0] basis [M];
        bit           valid [M];
        logic [M-1:0] v;
        int n, low;
        for (int b = 0; b < M; b++) begin basis[b] = '0; valid[b] = 1'b0; end
        for (int r = 0; r < W; r++) begin
            v = vin[r];
            for (int b = M - 1; b >= 0; b--) begin
                if (v[b]) begin
                    if (valid[b]) v = v ^ basis[b];
                    else begin basis[b] = v; valid[b] = 1'b1; break; end
                end
            end
        end
        for (int q = 0; q < M; q++)
            if (valid[q])
                for (int p = q + 1; p < M; p++)
                    if (valid[p] && basis[p][q]) basis[p] = basis[p] ^ basis[q];
        n = 0;
        low = 0;
        for (int b = M - 1; b >= 0; b--)
            if (valid[b]) begin mrow[n] = basis[b]; n++; low = b; end
        for (int r = n; r < W; r++) mrow[r] = '0;
        m_rank = n;
        m_lat = (EARLY && n == W) ? W + (M - 1 - low) + 1 : W + M;
    endtask

    task automatic model_reset();
        prev_fr = 1'b0; res_fr = 1'b0;
        run_t = -1; fin_cyc = -1; rd_r = -1;
        for (int r = 0; r < W; r++) mrow[r] = '0;
    endtask

    task automatic set_rows(input logic [M-1:0] a, b, c, d, e);
        vin[0] = a; vin[1] = b; vin[2] = c; vin[3] = d; vin[4] = e;
    endtask

    // Per-cycle comparison of all outputs against the model's schedule.
    always @(negedge clk) begin
        if (chk_en) begin
            logic         e_fin;
            logic         e_fr;
            logic [M-1:0] e_d;
            e_fin = (fin_cyc >= 0 && cyc == fin_cyc) || (rd_r >= 0 && cyc == rd_r + 1);
            e_d = '0;
            if (rd_r >= 0 && cyc >= rd_r + 1 && cyc <= rd_r + W)
                e_d = rd_rows[W - 1 - (cyc - rd_r - 1)];
            if (fin_cyc >= 0 && cyc >= fin_cyc) e_fr = res_fr;
            else if (run_t >= 0 && cyc > run_t) e_fr = 1'b0;
            else e_fr = prev_fr;
            chk("finish", finish, e_fin);
            chk("full_rank", full_rank, e_fr);
            chk("dout", dout, e_d);
        end
    end

    task automatic start_elim();
        model_compute();
        prev_fr = res_fr;
        run_t = cyc;
        res_fr = (m_rank == W);
        fin_cyc = cyc + m_lat;
        for (int r = 0; r < W; r++) begin
            start = (r == 0); mode = 1'b0; din = vin[r];
            step();
        end
        start = 1'b0;
        din = '0;
    endtask

    task automatic run_elim(input int lit_lat, input int inj_at);
        int t0, lat;
        bit seen;
        t0 = cyc;
        start_elim();
        seen = 1'b0;
        lat = -1;
        for (int k = 0; k < 300 && !seen; k++) begin
            if (cyc - t0 == inj_at) begin start = 1'b1; mode = 1'b0; din = '1; end
            step();
            start = 1'b0;
            din = '0;
            if (finish) begin seen = 1'b1; lat = cyc - t0; end
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL finish_timeout: got no finish within 300 cycles, expected one");
        end
        chk("latency", lat, (lit_lat >= 0) ? lit_lat : m_lat);
        step();
    endtask

    task automatic run_read(input bit use_lit, input logic [M-1:0] first_lit);
        rd_rows = mrow;
        rd_r = cyc;
        start = 1'b1; mode = 1'b1;
        step();
        start = 1'b0; mode = 1'b0;
        if (use_lit) chk("read_first", dout, first_lit);
        repeat (W) step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [M-1:0] a, b, c, x, y, z;
        model_reset();
        for (int r = 0; r < W; r++) vin[r] = '0;
        step();
        chk_en = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Readout before any elimination returns the cleared store.
        run_read(1'b1, zero);

        // Case 1: already-reduced unit rows.
        set_rows(one << 100, one << 99, one << 98, one << 97, one << 96);
        model_compute();
        chk("model_rank_c1", m_rank, 5);
        chk("model_row0_c1", mrow[0], one << 100);
        chk("model_row4_c1", mrow[4], one << 96);
        run_elim(EARLY ? 10 : 106, -1);
        run_read(1'b1, one << 96);

        // Case 2: duplicated and dependent rows.
        a = one << 100; b = (one << 50) | one; c = one << 50;
        set_rows(a, a, b, c, zero);
        model_compute();
        chk("model_rank_c2", m_rank, 3);
        chk("model_row0_c2", mrow[0], a);
        chk("model_row1_c2", mrow[1], one << 50);
        chk("model_row2_c2", mrow[2], one);
        chk("model_row3_c2", mrow[3], zero);
        run_elim(106, -1);
        run_read(1'b1, zero);

        // Case 3: all-zero rows scan the full width in either build.
        set_rows(zero, zero, zero, zero, zero);
        run_elim(106, -1);

        // Case 1 again with a stray mode-0 start while eliminating.
        set_rows(one << 100, one << 99, one << 98, one << 97, one << 96);
        run_elim(EARLY ? 10 : 106, W + 2);
        run_read(1'b1, one << 96);

        // Reset in the middle of ELIM, then the store must read back as zeros.
        set_rows(a, a, b, c, zero);
        start_elim();
        repeat (3) step();
        rst = 1'b1;
        step();
        model_reset();
        rst = 1'b0;
        step();
        run_read(1'b1, zero);

        // Fresh runs after reset: dense rank-3 set and a dense full-rank set.
        x = 101'h0_dead_beef_0123_4567_89ab_cdef;
        y = 101'h1a_5a5a_5a5a_0000_ffff_1234_5678;
        z = 101'h00_0000_0001_8000_0000_0000_0003;
        set_rows(x, y, x ^ y, z, x ^ z);
        model_compute();
        chk("model_rank_c5", m_rank, 3);
        run_elim(106, -1);
        run_read(1'b0, zero);

        set_rows(x, y, z, 101'h1f_0f0f_0000_0000_0000_0000_0001, one);
        run_elim(-1, -1);
        run_read(1'b0, zero);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
